// File: rtl/vc_arbiter.sv
// Two-VC read arbiter: strict priority by default, weighted round robin when
// VC_ARB_WRR_EN is defined. Strobes are registered; data_out lands two cycles after a strobe.
module vc_arbiter #(
  parameter int data_width   = 6,
  parameter int weight_width = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [weight_width-1:0] weight_VC0,
  input  logic                    empty_VC0,
  input  logic                    empty_VC1,
  input  logic [data_width-1:0]   data_VC0,
  input  logic [data_width-1:0]   data_VC1,
  input  logic                    pause,
  output logic                    rd_VC0,
  output logic                    rd_VC1,
  output logic [data_width-1:0]   data_out,
  output logic                    valid_out,
  output logic                    vc_out,
  output logic [1:0]              state
);

  localparam logic [1:0] ST_RESET  = 2'b00;
  localparam logic [1:0] ST_INIT   = 2'b01;
  localparam logic [1:0] ST_IDLE   = 2'b10;
  localparam logic [1:0] ST_ACTIVE = 2'b11;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic                  r_rd0;
  logic                  r_rd1;
  logic                  r_tag_valid;
  logic                  r_tag_vc;
  logic [data_width-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_vc_out;
  logic                  w_rd_en;
  logic                  w_pick_vc1;
  logic                  w_rd0;
  logic                  w_rd1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET: w_state_next = ST_INIT;
      ST_INIT:  w_state_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)
          w_state_next = ST_INIT;
        else if ((!empty_VC0 || !empty_VC1) && !pause)
          w_state_next = ST_ACTIVE;
      end
      default: begin
        if (init)
          w_state_next = ST_INIT;
        else if ((empty_VC0 && empty_VC1) || pause)
          w_state_next = ST_IDLE;
      end
    endcase
  end

  // Strobes follow the next state, so a read is only issued into a cycle spent in ACTIVE
  // and pause/init/empty suppress it combinationally in the cycle they are seen.
  assign w_rd_en = (w_state_next == ST_ACTIVE);

`ifdef VC_ARB_WRR_EN
  logic [weight_width-1:0] r_weight;
  logic [weight_width-1:0] r_wrr_cnt;
  logic [weight_width-1:0] w_weight_eff;

  assign w_weight_eff = (r_weight == '0) ? {{(weight_width-1){1'b0}}, 1'b1} : r_weight;
  assign w_pick_vc1   = empty_VC0 || (!empty_VC1 && (r_wrr_cnt >= w_weight_eff));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_weight  <= '0;
      r_wrr_cnt <= '0;
    end else begin
      if (r_state == ST_INIT)
        r_weight <= weight_VC0;
      if (empty_VC1 || w_rd1)
        r_wrr_cnt <= '0;
      else if (w_rd0)
        r_wrr_cnt <= r_wrr_cnt + 1'b1;
    end
  end
`else
  logic w_unused_weight;

  assign w_unused_weight = ^weight_VC0;
  assign w_pick_vc1      = empty_VC0;
`endif

  assign w_rd0 = w_rd_en && !w_pick_vc1;
  assign w_rd1 = w_rd_en && w_pick_vc1;

  // The strobe registers are the first tag stage; r_tag_* is the second, aligned with FIFO data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_rd0       <= 1'b0;
      r_rd1       <= 1'b0;
      r_tag_valid <= 1'b0;
      r_tag_vc    <= 1'b0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_vc_out    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rd0       <= w_rd0;
      r_rd1       <= w_rd1;
      r_tag_valid <= r_rd0 || r_rd1;
      r_tag_vc    <= r_rd1;
      r_valid_out <= r_tag_valid;
      r_vc_out    <= r_tag_valid && r_tag_vc;
      if (r_tag_valid)
        r_data_out <= r_tag_vc ? data_VC1 : data_VC0;
      else
        r_data_out <= '0;
    end
  end

  assign rd_VC0    = r_rd0;
  assign rd_VC1    = r_rd1;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign vc_out    = r_vc_out;
  assign state     = r_state;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed table-driven bench for vc_arbiter; WRR sequences run only when VC_ARB_WRR_EN is defined.
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] weight_VC0;
  logic       empty_VC0;
  logic       empty_VC1;
  logic [5:0] data_VC0;
  logic [5:0] data_VC1;
  logic       pause;
  logic       rd_VC0;
  logic       rd_VC1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       vc_out;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       ini;
    logic [3:0] w;
    logic       e0;
    logic       e1;
    logic       p;
    logic [5:0] d0;
    logic [5:0] d1;
    logic       rd0;
    logic       rd1;
    logic       vld;
    logic       vc;
    logic [5:0] dout;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  vc_arbiter #(.data_width(6), .weight_width(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .weight_VC0 (weight_VC0),
    .empty_VC0  (empty_VC0),
    .empty_VC1  (empty_VC1),
    .data_VC0   (data_VC0),
    .data_VC1   (data_VC1),
    .pause      (pause),
    .rd_VC0     (rd_VC0),
    .rd_VC1     (rd_VC1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .vc_out     (vc_out),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] outs();
    return {rd_VC0, rd_VC1, valid_out, vc_out, data_out, state};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got rd0/rd1/vld/vc/dout/st=%b_%b_%b_%b_%h_%b required %b_%b_%b_%b_%h_%b",
               name, act[11], act[10], act[9], act[8], act[7:2], act[1:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:2], exp[1:0]);
    end else begin
      $display("ok   %s: rd0/rd1/vld/vc/dout/st=%b_%b_%b_%b_%h_%b",
               name, act[11], act[10], act[9], act[8], act[7:2], act[1:0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

`ifdef VC_ARB_WRR_EN
  task automatic wrr_run(input logic [3:0] w, input int n, input logic [7:0] pattern);
    init = 1'b1; weight_VC0 = w; empty_VC0 = 1'b1; empty_VC1 = 1'b1;
    cyc();
    init = 1'b0;
    cyc();
    empty_VC0 = 1'b0; empty_VC1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      check($sformatf("wrr_w%0d_grant%0d", w, i), outs() & 12'hC03,
            {pattern[i] ? 2'b01 : 2'b10, 8'h00, 2'b11});
    end
    empty_VC0 = 1'b1; empty_VC1 = 1'b1;
    repeat (3) cyc();
  endtask
`endif

  initial begin
    reset = 1'b1; init = 1'b0; weight_VC0 = '0; empty_VC0 = 1'b1; empty_VC1 = 1'b1;
    data_VC0 = '0; data_VC1 = '0; pause = 1'b0;

    //               rst ini w  e0 e1 p  d0     d1      rd0 rd1 vld vc dout   st
    tbl.push_back('{1, 0, 0, 1, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd0});
    tbl.push_back('{0, 1, 3, 1, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd1});
    tbl.push_back('{0, 1, 3, 1, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd1});
    tbl.push_back('{0, 0, 3, 1, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});
    // VC0 alone with three words
    tbl.push_back('{0, 0, 0, 0, 1, 0, 6'h00, 6'h00,  1, 0, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 6'h00, 6'h00,  1, 0, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 6'h11, 6'h00,  1, 0, 1, 0, 6'h11, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h12, 6'h00,  0, 0, 1, 0, 6'h12, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h13, 6'h00,  0, 0, 1, 0, 6'h13, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h13, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});
    // both non-empty: VC1 waits for VC0 to drain
    tbl.push_back('{0, 0, 0, 0, 0, 0, 6'h13, 6'h00,  1, 0, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 6'h13, 6'h00,  1, 0, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 6'h31, 6'h00,  0, 1, 1, 0, 6'h31, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h32, 6'h00,  0, 0, 1, 0, 6'h32, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h32, 6'h21,  0, 0, 1, 1, 6'h21, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h32, 6'h21,  0, 0, 0, 0, 6'h00, 2'd2});
    // VC1 stream interrupted by pause
    tbl.push_back('{0, 0, 0, 1, 0, 0, 6'h00, 6'h21,  0, 1, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 6'h00, 6'h21,  0, 1, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 6'h00, 6'h2A,  0, 0, 1, 1, 6'h2A, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 6'h00, 6'h2B,  0, 0, 1, 1, 6'h2B, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 6'h00, 6'h2B,  0, 0, 0, 0, 6'h00, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 6'h00, 6'h2B,  0, 1, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h00, 6'h2B,  0, 0, 0, 0, 6'h00, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h00, 6'h2C,  0, 0, 1, 1, 6'h2C, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h00, 6'h2C,  0, 0, 0, 0, 6'h00, 2'd2});
    // init raised while ACTIVE; the in-flight word still arrives
    tbl.push_back('{0, 0, 0, 0, 1, 0, 6'h00, 6'h00,  1, 0, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 1, 5, 0, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd1});
    tbl.push_back('{0, 1, 5, 0, 1, 0, 6'h35, 6'h00,  0, 0, 1, 0, 6'h35, 2'd1});
    tbl.push_back('{0, 0, 5, 0, 1, 0, 6'h35, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 6'h35, 6'h00,  1, 0, 0, 0, 6'h00, 2'd3});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h35, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h36, 6'h00,  0, 0, 1, 0, 6'h36, 2'd2});
    // pause and init hold off a request in IDLE
    tbl.push_back('{0, 0, 0, 0, 1, 1, 6'h36, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});
    tbl.push_back('{0, 1, 0, 0, 1, 0, 6'h36, 6'h00,  0, 0, 0, 0, 6'h00, 2'd1});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 6'h00, 6'h00,  0, 0, 0, 0, 6'h00, 2'd2});

    #1;
    check("reset_state", outs(), 12'h000);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; init = tbl[i].ini; weight_VC0 = tbl[i].w;
      empty_VC0 = tbl[i].e0; empty_VC1 = tbl[i].e1; pause = tbl[i].p;
      data_VC0 = tbl[i].d0; data_VC1 = tbl[i].d1;
      cyc();
      check($sformatf("row%0d", i), outs(),
            {tbl[i].rd0, tbl[i].rd1, tbl[i].vld, tbl[i].vc, tbl[i].dout, tbl[i].st});
    end

    // reset asserted mid-stream clears outputs without waiting for a clock edge
    empty_VC0 = 1'b0; data_VC0 = 6'h15;
    cyc();
    check("stream_rd0_a", outs(), {4'b1000, 6'h00, 2'd3});
    cyc();
    check("stream_rd0_b", outs(), {4'b1000, 6'h00, 2'd3});
    cyc();
    check("stream_vld", outs(), {4'b1010, 6'h15, 2'd3});
    #2 reset = 1'b1;
    #1 check("async_reset", outs(), 12'h000);
    @(negedge clk);
    reset = 1'b0; empty_VC0 = 1'b1;
    cyc();
    check("post_reset_init", outs(), {4'b0000, 6'h00, 2'd1});
    cyc();
    check("post_reset_idle", outs(), {4'b0000, 6'h00, 2'd2});
    cyc();
    check("post_reset_quiet", outs(), {4'b0000, 6'h00, 2'd2});

`ifdef VC_ARB_WRR_EN
    wrr_run(4'd2, 6, 8'b0010_0100);
    wrr_run(4'd0, 4, 8'b0000_1010);
    wrr_run(4'd5, 6, 8'b0010_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter: data_width, default 6, word width of both VC FIFOs and the output.
REQ-002 Parameter: weight_width, default 4, width of the VC0 weight register.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; resets all state immediately.
REQ-005 Port: init  input  1  level; high requests (re)configuration.
REQ-006 Port: weight_VC0  input  weight_width  VC0 weight, latched in INIT.
REQ-007 Port: empty_VC0, empty_VC1  input  1 each  FIFO empty flags.
REQ-008 Port: data_VC0, data_VC1  input  data_width each  FIFO read data, valid one cycle after the read strobe.
REQ-009 Port: pause  input  1  downstream almost-full back-pressure.
REQ-010 Port: rd_VC0, rd_VC1  output  1 each  FIFO read strobes, registered.
REQ-011 Port: data_out  output  data_width  arbitrated word, registered.
REQ-012 Port: valid_out  output  1  data_out qualifier, registered.
REQ-013 Port: vc_out  output  1  source of data_out (0 = VC0, 1 = VC1).
REQ-014 Port: state  output  2  FSM state: RESET=00, INIT=01, IDLE=10, ACTIVE=11.

Function
REQ-015 FSM transitions: RESET->INIT on first edge after reset low; INIT->IDLE when init=0; IDLE->ACTIVE when (!empty_VC0 | !empty_VC1) & !pause & !init; ACTIVE->IDLE when both empty or pause=1; IDLE/ACTIVE->INIT when init=1.
REQ-016 In INIT, weight register loads weight_VC0 every cycle; the value held on INIT exit stays in force.
REQ-017 Read strobes SHALL assert only in ACTIVE, with pause=0 and init=0, at most one per cycle, never to a FIFO whose empty flag is high in that cycle.
REQ-018 Default policy (macro absent): strict priority; VC0 read whenever !empty_VC0, else VC1 if !empty_VC1.
REQ-019 Back-to-back reads of one FIFO are allowed every cycle; the empty flag sampled each cycle is authoritative.
REQ-020 Latency: read strobe at edge n -> FIFO data at n+1 -> data_out/valid_out/vc_out at n+2; a two-stage source-tag pipeline tracks this.
REQ-021 Reads issued before pause, init, or an ACTIVE exit SHALL still deliver data (up to 2 words in flight).
REQ-022 valid_out=0 in every cycle with no delivered word; data_out SHALL then be 0.
REQ-023 pause and init SHALL gate strobes in the same cycle they are high (combinational gating before the strobe register).

Reset
REQ-024 On reset high: state=RESET, rd_VC0=rd_VC1=0, data_out=0, valid_out=0, vc_out=0, weight=0, WRR counter=0, tag pipeline cleared, all asynchronously.
REQ-025 Reset mid-transfer discards in-flight words; no valid_out after reset release until a new read is issued.

Configuration
REQ-026 Macro VC_ARB_WRR_EN defined: weighted round robin; VC0 gets up to W consecutive reads while VC1 non-empty (W = weight, 0 treated as 1), then one VC1 read; counter clears on a VC1 grant or when VC1 is empty.
REQ-027 Macro VC_ARB_WRR_EN undefined: strict priority per REQ-018; the weight register and counter are absent; weight_VC0 is ignored.

Verification
REQ-028 Reset high mid-stream -> all outputs 0 in the same cycle; state=00; after release state goes 01 then 10 with init=0.
REQ-029 VC0 holds 3 words (0x11,0x12,0x13), VC1 empty -> rd_VC0 on 3 consecutive cycles; valid_out on 3 cycles starting 2 cycles after the first strobe; vc_out=0; exactly 3 reads.
REQ-030 Both non-empty, macro off -> VC1 untouched until empty_VC0=1, then rd_VC1 the next cycle.
REQ-031 Macro on, weight=2, both with 6 words -> grant order 0,0,1,0,0,1,0,0,1...; weight=0 -> order 0,1,0,1.
REQ-032 pause raised during streaming -> strobes drop the same cycle; 2 in-flight words still valid; state=10; after pause drops, streaming resumes with no lost or duplicated words.
REQ-033 init raised in ACTIVE with weight_VC0=5 -> strobes stop, state=01; after init drops, state=10, then 11, and the new weight is used.
